// File: rtl/hist_bank_ctrl.sv
// -----------------------------------------------------------------------------
// hist_bank_ctrl
//
// Sequencer for NBANK parallel histogram banks. Each bank covers BINS
// consecutive grey levels: bank k owns bins k*BINS .. k*BINS+BINS-1.
//
// One frame runs as follows:
//   1. A common start pulse goes to every bank.
//   2. The controller waits until all banks report ready, which means their
//      clear has finished.
//   3. One pixel stream is gated through to every bank. A pixel is accepted
//      only when all banks are ready.
//   4. The controller collects the one-cycle done pulse of every bank.
//   5. Every bin is read out as one ordered stream, bin 0 .. NBANK*BINS-1.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   start             begin a frame; ignored while a frame is in progress
//   busy              a frame is in progress
//   done              one-cycle pulse after the last bin has been accepted
//   pix_*             upstream pixel stream (valid/ready, 8-bit grey level, last)
//   bank_start        one-cycle start pulse, broadcast to all banks
//   bank_busy         per-bank busy (status only, not used for sequencing)
//   bank_done         per-bank one-cycle done pulse
//   bank_ready        per-bank pixel ready
//   bank_pix_*        pixel stream, broadcast to all banks
//   bank_rd_addr      shared bin read address
//   bank_rd_data      concatenated bank read data; bank k sits at
//                     [k*COUNT_WIDTH +: COUNT_WIDTH]; one-cycle read latency
//   hist_*            ordered bin stream (valid/ready, bin index, count, last)
// -----------------------------------------------------------------------------
module hist_bank_ctrl #(
  parameter int NBANK       = 16,
  parameter int BINS        = 16,
  parameter int COUNT_WIDTH = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,

  input  logic                         start,
  output logic                         busy,
  output logic                         done,

  input  logic                         pix_valid,
  input  logic [7:0]                   pix_data,
  input  logic                         pix_last,
  output logic                         pix_ready,

  output logic                         bank_start,
  input  logic [NBANK-1:0]             bank_busy,
  input  logic [NBANK-1:0]             bank_done,
  input  logic [NBANK-1:0]             bank_ready,
  output logic                         bank_pix_valid,
  output logic [7:0]                   bank_pix_data,
  output logic                         bank_pix_last,
  output logic [$clog2(BINS)-1:0]      bank_rd_addr,
  input  logic [NBANK*COUNT_WIDTH-1:0] bank_rd_data,

  output logic                         hist_valid,
  input  logic                         hist_ready,
  output logic [7:0]                   hist_bin,
  output logic [COUNT_WIDTH-1:0]       hist_count,
  output logic                         hist_last
);

  localparam int AW    = $clog2(BINS);
  localparam int NBINS = NBANK * BINS;
  localparam logic [7:0] LAST_G = 8'(NBINS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_CLR_WAIT,
    S_RUN,
    S_DRAIN,
    S_RADDR,
    S_RDATA,
    S_OUT,
    S_DONE
  } state_t;

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic [NBANK-1:0]       done_mask_q, done_mask_d;
  logic [7:0]             g_q, g_d;
  logic [AW-1:0]          rd_addr_q, rd_addr_d;
  logic                   hist_valid_q, hist_valid_d;
  logic [7:0]             hist_bin_q, hist_bin_d;
  logic [COUNT_WIDTH-1:0] hist_count_q, hist_count_d;
  logic                   hist_last_q, hist_last_d;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  logic                   all_ready;
  logic                   pix_xfer;
  logic [7:0]             g_inc;
  logic [7:0]             bank_sel;
  logic [COUNT_WIDTH-1:0] rd_slice;

  // bank_busy is status only; sequencing relies on bank_ready and bank_done.
  logic unused_bank_busy;
  assign unused_bank_busy = ^bank_busy;

  assign all_ready = &bank_ready;
  assign g_inc     = g_q + 8'd1;

  // The upper bits of the global bin index select the bank.
  // The lower AW bits form the shared read address.
  assign bank_sel = g_q >> AW;

  always_comb begin
    rd_slice = '0;
    for (int k = 0; k < NBANK; k++) begin
      if (bank_sel == 8'(k)) begin
        rd_slice = bank_rd_data[k*COUNT_WIDTH +: COUNT_WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel gating
  // ---------------------------------------------------------------------------
  // Pixels pass only in RUN, and only when every bank can take them. The banks
  // see the same valid, so no bank can miss a pixel that another one counted.
  // Out-of-range grey levels are forwarded unchanged; the banks discard them.
  assign pix_ready      = (state_q == S_RUN) && all_ready;
  assign pix_xfer       = pix_valid && pix_ready;
  assign bank_pix_valid = pix_xfer;
  assign bank_pix_data  = pix_data;
  assign bank_pix_last  = pix_last;

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_mask_d  = done_mask_q;
    g_d          = g_q;
    rd_addr_d    = rd_addr_q;
    hist_valid_d = hist_valid_q;
    hist_bin_d   = hist_bin_q;
    hist_count_d = hist_count_q;
    hist_last_d  = hist_last_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_START;
          busy_d      = 1'b1;
          done_mask_d = '0;
        end
      end

      S_START: begin
        state_d = S_CLR_WAIT;
      end

      // The banks drop ready while they clear. Wait until all are ready again.
      S_CLR_WAIT: begin
        if (all_ready) begin
          state_d = S_RUN;
        end
      end

      // A bank may signal done early (a bank fault). That pulse is only
      // recorded here; it does not end the frame.
      S_RUN: begin
        done_mask_d = done_mask_q | bank_done;
        if (pix_xfer && pix_last) begin
          state_d = S_DRAIN;
        end
      end

      // Pulses keep accumulating in the mask, so skewed pulses are never lost.
      // Readout starts only when every bank has reported done.
      S_DRAIN: begin
        done_mask_d = done_mask_q | bank_done;
        if (&done_mask_q) begin
          state_d   = S_RADDR;
          g_d       = 8'd0;
          rd_addr_d = '0;
        end
      end

      // The read address for g is already on bank_rd_addr. The banks register
      // it on this edge, so their data is valid during RDATA.
      S_RADDR: begin
        state_d = S_RDATA;
      end

      S_RDATA: begin
        hist_count_d = rd_slice;
        hist_bin_d   = g_q;
        hist_last_d  = (g_q == LAST_G);
        hist_valid_d = 1'b1;
        state_d      = S_OUT;
      end

      // All hist_* outputs hold until the bin is accepted. The address for the
      // next bin is loaded together with the index, so it is stable on entry
      // to RADDR.
      S_OUT: begin
        if (hist_ready) begin
          hist_valid_d = 1'b0;
          if (hist_last_q) begin
            state_d = S_DONE;
          end else begin
            g_d       = g_inc;
            rd_addr_d = g_inc[AW-1:0];
            state_d   = S_RADDR;
          end
        end
      end

      // A start seen in this cycle is dropped; IDLE is entered unconditionally.
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // A reset in the middle of a frame aborts it. The frame does not resume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_mask_q  <= '0;
      g_q          <= 8'd0;
      rd_addr_q    <= '0;
      hist_valid_q <= 1'b0;
      hist_bin_q   <= 8'd0;
      hist_count_q <= '0;
      hist_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_mask_q  <= done_mask_d;
      g_q          <= g_d;
      rd_addr_q    <= rd_addr_d;
      hist_valid_q <= hist_valid_d;
      hist_bin_q   <= hist_bin_d;
      hist_count_q <= hist_count_d;
      hist_last_q  <= hist_last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = busy_q;
  assign done         = (state_q == S_DONE);
  assign bank_start   = (state_q == S_START);
  assign bank_rd_addr = rd_addr_q;
  assign hist_valid   = hist_valid_q;
  assign hist_bin     = hist_bin_q;
  assign hist_count   = hist_count_q;
  assign hist_last    = hist_last_q;

endmodule

// File: tb/tb_hist_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hist_bank_ctrl
//
// Bench for hist_bank_ctrl with 16 banks of 16 bins.
//
// Bank behaviour is modelled here. Each bank clears on bank_start and counts
// the pixels in its range while it is ready. After the last pixel it pulses
// done following a programmable delay. Read data is returned with one cycle
// of latency.
//
// The expected readout is an array histogram built from the pixel list of
// each frame. That stream is bin 0..255 with the histogram counts, and
// hist_last set only on bin 255.
// -----------------------------------------------------------------------------
module tb_hist_bank_ctrl;

  localparam int NBANK = 16;
  localparam int BINS  = 16;
  localparam int CW    = 24;
  localparam int NBINS = NBANK * BINS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  busy, done;
  logic                  pix_valid = 1'b0;
  logic [7:0]            pix_data = 8'd0;
  logic                  pix_last = 1'b0;
  logic                  pix_ready;
  logic                  bank_start;
  logic [NBANK-1:0]      bank_busy, bank_done, bank_ready;
  logic                  bank_pix_valid;
  logic [7:0]            bank_pix_data;
  logic                  bank_pix_last;
  logic [3:0]            bank_rd_addr;
  logic [NBANK*CW-1:0]   bank_rd_data;
  logic                  hist_valid;
  logic                  hist_ready = 1'b1;
  logic [7:0]            hist_bin;
  logic [CW-1:0]         hist_count;
  logic                  hist_last;

  hist_bank_ctrl #(.NBANK(NBANK), .BINS(BINS), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
    .bank_start(bank_start), .bank_busy(bank_busy), .bank_done(bank_done),
    .bank_ready(bank_ready), .bank_pix_valid(bank_pix_valid), .bank_pix_data(bank_pix_data),
    .bank_pix_last(bank_pix_last), .bank_rd_addr(bank_rd_addr), .bank_rd_data(bank_rd_data),
    .hist_valid(hist_valid), .hist_ready(hist_ready), .hist_bin(hist_bin),
    .hist_count(hist_count), .hist_last(hist_last)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Bank models
  // ---------------------------------------------------------------------------
  int               bcnt [NBANK][BINS] = '{default: '{default: 0}};
  int               clr_ctr [NBANK]    = '{default: 0};
  int               done_ctr [NBANK]   = '{default: -1};
  int               dly [NBANK]        = '{default: 1};
  logic [NBANK-1:0] brdy  = '1;
  logic [NBANK-1:0] bdone = '0;
  logic [NBANK*CW-1:0] brd = '0;
  bit               jitter = 1'b0;
  int               beats = 0;
  int               b3cyc = -1;

  assign bank_ready   = brdy;
  assign bank_done    = bdone;
  assign bank_busy    = ~brdy;
  assign bank_rd_data = brd;

  always @(posedge clk) begin
    bdone <= '0;
    if (bank_start) begin
      beats <= 0;
      b3cyc <= -1;
      for (int k = 0; k < NBANK; k++) begin
        clr_ctr[k]  <= 2 + int'($urandom_range(3));
        brdy[k]     <= 1'b0;
        done_ctr[k] <= -1;
        for (int b = 0; b < BINS; b++) bcnt[k][b] <= 0;
      end
    end else begin
      for (int k = 0; k < NBANK; k++) begin
        if (clr_ctr[k] > 1) clr_ctr[k] <= clr_ctr[k] - 1;
        else if (clr_ctr[k] == 1) begin
          clr_ctr[k] <= 0;
          brdy[k]    <= 1'b1;
        end else if (jitter) brdy[k] <= ($urandom_range(15) != 0);
      end
      if (bank_pix_valid && brdy[bank_pix_data / BINS]) begin
        beats <= beats + 1;
        bcnt[bank_pix_data / BINS][bank_pix_data % BINS] <=
          bcnt[bank_pix_data / BINS][bank_pix_data % BINS] + 1;
        if (bank_pix_last)
          for (int k = 0; k < NBANK; k++) done_ctr[k] <= dly[k];
      end
      for (int k = 0; k < NBANK; k++) begin
        if (done_ctr[k] == 0) begin
          bdone[k]    <= 1'b1;
          done_ctr[k] <= -1;
          if (k == 3) b3cyc <= cyc + 1;
        end else if (done_ctr[k] > 0) done_ctr[k] <= done_ctr[k] - 1;
      end
    end
    for (int k = 0; k < NBANK; k++) brd[k*CW +: CW] <= CW'(bcnt[k][bank_rd_addr]);
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  int         exp_hist [NBINS];
  int         exp_next = 0;
  int         done_cnt = 0;
  int         bst_cnt = 0;
  int         first_hv = -1;
  int         bp_bin = -1;
  int         bp_len = 0;
  int         stall_n = 0;
  bit         rand_rdy = 1'b0;
  bit         stalled_prev = 1'b0;
  logic [7:0] held_bin = 8'd0;
  logic [CW-1:0] held_cnt = '0;
  logic       held_last = 1'b0;
  logic [7:0] pix_q [$];

  // Advance one cycle and watch the hist stream. Then decide hist_ready for
  // the coming edge; a bin counts as accepted when it is valid and ready.
  task automatic tick();
    bit rdy;
    @(negedge clk);
    if (!rst_n) begin
      hist_ready   = 1'b1;
      stalled_prev = 1'b0;
      return;
    end
    if (done) done_cnt++;
    if (bank_start) bst_cnt++;
    if (hist_valid && first_hv < 0) first_hv = cyc;
    rdy = 1'b1;
    if (hist_valid) begin
      if (stalled_prev) begin
        check("hold_bin", hist_bin, held_bin);
        check("hold_cnt", hist_count, held_cnt);
        check("hold_last", hist_last, held_last);
      end
      if (int'(hist_bin) == bp_bin && stall_n < bp_len) begin
        rdy = 1'b0;
        stall_n++;
      end else if (rand_rdy) rdy = ($urandom_range(2) != 0);
      if (rdy) begin
        check("bin_idx", hist_bin, exp_next);
        check("bin_cnt", hist_count, (exp_next < NBINS) ? exp_hist[exp_next] : -1);
        check("bin_last", hist_last, exp_next == NBINS - 1);
        exp_next++;
      end
      stalled_prev = !rdy;
      held_bin = hist_bin;
      held_cnt = hist_count;
      held_last = hist_last;
    end else begin
      if (stalled_prev) check("hold_vld", hist_valid, 1);
      stalled_prev = 1'b0;
    end
    hist_ready = rdy;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_done"}, done, 0);
    check({pfx, "_bstart"}, bank_start, 0);
    check({pfx, "_hvalid"}, hist_valid, 0);
    check({pfx, "_hlast"}, hist_last, 0);
    check({pfx, "_hbin"}, hist_bin, 0);
    check({pfx, "_hcount"}, hist_count, 0);
    check({pfx, "_rdaddr"}, bank_rd_addr, 0);
    check({pfx, "_pixrdy"}, pix_ready, 0);
  endtask

  task automatic run_frame(input bit st_run, input bit st_out, input bit junk, input int abort_at);
    bit xfer;
    bit sp;
    foreach (exp_hist[i]) exp_hist[i] = 0;
    foreach (pix_q[i]) exp_hist[pix_q[i]]++;
    exp_next = 0; done_cnt = 0; bst_cnt = 0; first_hv = -1;
    stall_n = 0; stalled_prev = 1'b0; sp = 1'b0;

    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_set", busy, 1);

    for (int i = 0; i < pix_q.size(); i++) begin
      if ($urandom_range(3) == 0) begin
        pix_valid = 1'b0;
        tick();
      end
      pix_valid = 1'b1;
      pix_data  = pix_q[i];
      pix_last  = (i == pix_q.size() - 1);
      if (st_run && i == 1) start = 1'b1;
      for (int w = 0; ; w++) begin
        #1;
        check("fwd_vld", bank_pix_valid, pix_ready);
        check("fwd_data", bank_pix_data, pix_data);
        check("fwd_last", bank_pix_last, pix_last);
        if (!(&bank_ready)) check("rdy_gate", pix_ready, 0);
        xfer = pix_ready;
        tick();
        start = 1'b0;
        if (xfer) break;
        if (w > 500) begin
          check("pix_timeout", 0, 1);
          break;
        end
      end
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;

    if (junk) begin
      repeat (3) begin
        pix_valid = 1'b1;
        pix_data  = 8'd99;
        pix_last  = 1'b1;
        #1;
        check("drain_rdy", pix_ready, 0);
        check("drain_fwd", bank_pix_valid, 0);
        tick();
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
    end

    for (int w = 0; w < 6000 && done_cnt == 0; w++) begin
      if (st_out && exp_next == 50 && !sp) begin
        start = 1'b1;
        sp = 1'b1;
      end else start = 1'b0;
      if (abort_at >= 0 && exp_next >= abort_at) begin
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_hvalid", hist_valid, 0);
        return;
      end
      tick();
    end
    start = 1'b0;
    if (done_cnt == 0) check("done_timeout", 0, 1);
    tick();
    tick();
    check("done_pulses", done_cnt, 1);
    check("bank_starts", bst_cnt, 1);
    check("bins_seen", exp_next, NBINS);
    check("pix_beats", beats, pix_q.size());
    check("busy_clear", busy, 0);
  endtask

  task automatic set_dly(input int v);
    for (int k = 0; k < NBANK; k++) dly[k] = v;
  endtask

  task automatic basic_pixels();
    pix_q = {};
    pix_q.push_back(8'd0);
    pix_q.push_back(8'd17);
    pix_q.push_back(8'd17);
    pix_q.push_back(8'd255);
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    tick();

    // Basic frame
    basic_pixels();
    set_dly(1);
    run_frame(0, 0, 0, -1);

    // Backpressure at bin 17
    bp_bin = 17;
    bp_len = 5;
    run_frame(0, 0, 0, -1);
    bp_bin = -1;
    bp_len = 0;

    // Start while busy, in RUN and during readout
    run_frame(1, 1, 0, -1);

    // Pixels offered outside RUN
    set_dly(4);
    run_frame(0, 0, 1, -1);

    // Skewed done pulses: bank 3 arrives late
    pix_q = {};
    repeat (8) pix_q.push_back(8'($urandom_range(255)));
    set_dly(0);
    dly[3] = 5;
    run_frame(0, 0, 0, -1);
    check("b3_gap", first_hv - b3cyc, 4);

    // Reset during readout, then a one-pixel frame
    basic_pixels();
    set_dly(1);
    run_frame(0, 0, 0, 100);
    pix_q = {};
    pix_q.push_back(8'd5);
    run_frame(0, 0, 0, -1);

    // Random frames with ready jitter and random downstream ready
    jitter   = 1'b1;
    rand_rdy = 1'b1;
    repeat (3) begin
      pix_q = {};
      repeat (10 + $urandom_range(50)) pix_q.push_back(8'($urandom_range(255)));
      for (int k = 0; k < NBANK; k++) dly[k] = int'($urandom_range(6));
      run_frame(0, 0, 0, -1);
    end
    jitter   = 1'b0;
    rand_rdy = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
